// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255A-style PPI port channel.
// Holds the mode/direction encodings and the control-word bit positions
// that the bus-side control decode uses when it builds cfg_mode/cfg_dir.
package ppi_pkg;

  typedef enum logic {
    MODE_BASIC   = 1'b0,
    MODE_STROBED = 1'b1
  } ppi_mode_e;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } ppi_dir_e;

  // Control-word layout (mode-set word, flag bit = 1)
  localparam int unsigned CW_FLAG_BIT    = 7;
  localparam int unsigned CW_A_MODE_MSB  = 6;
  localparam int unsigned CW_A_MODE_LSB  = 5;
  localparam int unsigned CW_A_DIR_BIT   = 4;
  localparam int unsigned CW_CU_DIR_BIT  = 3;
  localparam int unsigned CW_B_MODE_BIT  = 2;
  localparam int unsigned CW_B_DIR_BIT   = 1;
  localparam int unsigned CW_CL_DIR_BIT  = 0;

endpackage

// File: rtl/ppi_hs_port_if.sv
// Bus and peripheral-pin bundle for one ppi_hs_port channel.
//   cfg_wr/cfg_mode/cfg_dir : configuration load (flushes the buffer)
//   inte_set/inte_clr       : interrupt-enable control pulses
//   bus_rd/bus_wr/bus_din/bus_dout : decoded CPU access to this port
//   port_in/port_out/port_oe : peripheral data pins and driver enable
//   stb_n/ack_n             : active-low input strobe / output acknowledge
//   ibf/obf_n/intr/ovf/level : handshake status and buffer occupancy
// slave = the port channel, master = the bus/peripheral side driving it.
interface ppi_hs_port_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          cfg_wr;
  logic          cfg_mode;
  logic          cfg_dir;
  logic          inte_set;
  logic          inte_clr;
  logic          bus_rd;
  logic          bus_wr;
  logic [DW-1:0] bus_din;
  logic [DW-1:0] bus_dout;
  logic [DW-1:0] port_in;
  logic [DW-1:0] port_out;
  logic          port_oe;
  logic          stb_n;
  logic          ack_n;
  logic          ibf;
  logic          obf_n;
  logic          intr;
  logic          ovf;
  logic [AW:0]   level;

  modport slave (
    input  cfg_wr, cfg_mode, cfg_dir, inte_set, inte_clr,
    input  bus_rd, bus_wr, bus_din, port_in, stb_n, ack_n,
    output bus_dout, port_out, port_oe, ibf, obf_n, intr, ovf, level
  );

  modport master (
    output cfg_wr, cfg_mode, cfg_dir, inte_set, inte_clr,
    output bus_rd, bus_wr, bus_din, port_in, stb_n, ack_n,
    input  bus_dout, port_out, port_oe, ibf, obf_n, intr, ovf, level
  );

endinterface

// File: rtl/ppi_fifo.sv
// Synchronous FIFO used as the mode-1 handshake buffer.
// Ports: clk, reset (sync, active-high), flush, push/wdata, pop,
//        head (entry at the read pointer), full, empty, level.
// A pop on an empty buffer is ignored; a push on a full buffer is dropped
// unless a pop happens in the same cycle, in which case both take effect.
module ppi_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign level   = cnt_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; empty gates every consumer of head.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ppi_hs_port.sv
// One 8255A-style PPI port channel: mode 0 (basic, latched) and mode 1
// (strobed, DEPTH-entry buffered) in either direction.
// Ports: clk, reset (sync, active-high), hs (ppi_hs_port_if.slave) carrying
//        configuration, CPU bus access, peripheral pins and status flags.
// Optional build macro PPI_SYNC_STAGES_EN: adds a 2-flop synchroniser on
// stb_n/ack_n and a matching 2-cycle delay on port_in.
module ppi_hs_port
  import ppi_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  ppi_hs_port_if.slave  hs
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          stb_sync, ack_sync;
  logic [DW-1:0] pin_sync;

`ifdef PPI_SYNC_STAGES_EN
  logic [1:0]    stb_s_q, ack_s_q;
  logic [DW-1:0] pin_s1_q, pin_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stb_s_q  <= '1;
      ack_s_q  <= '1;
      pin_s1_q <= '0;
      pin_s2_q <= '0;
    end else begin
      stb_s_q  <= {stb_s_q[0], hs.stb_n};
      ack_s_q  <= {ack_s_q[0], hs.ack_n};
      pin_s1_q <= hs.port_in;
      pin_s2_q <= pin_s1_q;
    end
  end

  assign stb_sync = stb_s_q[1];
  assign ack_sync = ack_s_q[1];
  assign pin_sync = pin_s2_q;
`else
  assign stb_sync = hs.stb_n;
  assign ack_sync = hs.ack_n;
  assign pin_sync = hs.port_in;
`endif

  ppi_mode_e     mode_q;
  ppi_dir_e      dir_q;
  logic          inte_q, inte_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] port_out_q, port_out_d;
  logic [DW-1:0] pin_q;
  logic          stb_prev_q, ack_prev_q;

  logic          stb_fall, ack_fall;
  logic          s_in, s_out, basic_out;

  logic          fifo_push, fifo_pop;
  logic [DW-1:0] fifo_wdata, fifo_head;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_level;

  assign stb_fall  = stb_prev_q & ~stb_sync;
  assign ack_fall  = ack_prev_q & ~ack_sync;
  assign s_in      = (mode_q == MODE_STROBED) && (dir_q == DIR_IN);
  assign s_out     = (mode_q == MODE_STROBED) && (dir_q == DIR_OUT);
  assign basic_out = (mode_q == MODE_BASIC)   && (dir_q == DIR_OUT);

  // cfg_wr suppresses every buffer operation in its cycle.
  always_comb begin
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_wdata = pin_sync;
    if (!hs.cfg_wr) begin
      if (s_in) begin
        fifo_push = stb_fall;
        fifo_pop  = hs.bus_rd;
      end else if (s_out) begin
        fifo_push  = hs.bus_wr;
        fifo_pop   = ack_fall;
        fifo_wdata = hs.bus_din;
      end
    end
  end

  always_comb begin
    ovf_d      = ovf_q | (fifo_push & fifo_full & ~fifo_pop);
    inte_d     = inte_q;
    port_out_d = port_out_q;
    if (hs.inte_set) inte_d = 1'b1;
    if (hs.inte_clr) inte_d = 1'b0;
    // In mode 1 output, keep a copy of the head so the pins hold the
    // last value after the final acknowledge empties the buffer.
    if (basic_out && hs.bus_wr)    port_out_d = hs.bus_din;
    else if (s_out && !fifo_empty) port_out_d = fifo_head;
    if (hs.cfg_wr) begin
      ovf_d      = 1'b0;
      inte_d     = 1'b0;
      port_out_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= MODE_BASIC;
      dir_q      <= DIR_IN;
      inte_q     <= 1'b0;
      ovf_q      <= 1'b0;
      port_out_q <= '0;
      pin_q      <= '0;
      stb_prev_q <= 1'b1;
      ack_prev_q <= 1'b1;
    end else begin
      if (hs.cfg_wr) begin
        mode_q <= ppi_mode_e'(hs.cfg_mode);
        dir_q  <= ppi_dir_e'(hs.cfg_dir);
      end
      inte_q     <= inte_d;
      ovf_q      <= ovf_d;
      port_out_q <= port_out_d;
      pin_q      <= pin_sync;
      stb_prev_q <= stb_sync;
      ack_prev_q <= ack_sync;
    end
  end

  ppi_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (hs.cfg_wr),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  logic [DW-1:0] port_out_w;
  assign port_out_w = (s_out && !fifo_empty) ? fifo_head : port_out_q;

  always_comb begin
    if (s_in)                 hs.bus_dout = fifo_empty ? '0 : fifo_head;
    else if (dir_q == DIR_OUT) hs.bus_dout = port_out_w;
    else                      hs.bus_dout = pin_q;
  end

  assign hs.port_out = port_out_w;
  assign hs.port_oe  = (dir_q == DIR_OUT);
  assign hs.ibf      = s_in & ~fifo_empty;
  assign hs.obf_n    = ~(s_out & ~fifo_empty);
  // Input: interrupt once the strobe has returned high with data waiting.
  // Output: interrupt while there is room and the acknowledge is idle.
  assign hs.intr     = (s_in  & inte_q & ~fifo_empty & stb_prev_q) |
                       (s_out & inte_q & ~fifo_full  & ack_prev_q);
  assign hs.ovf      = ovf_q;
  assign hs.level    = fifo_level;

endmodule

// File: tb/tb_ppi_hs_port.sv
module tb_ppi_hs_port;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic snap = 1'b0;

  always #5 clk = ~clk;

  ppi_hs_port_if #(.DW(DW), .DEPTH(DEPTH)) hs ();

  ppi_hs_port #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .hs    (hs)
  );

  typedef struct packed {
    logic [7:0] po;
    logic       oe;
    logic       ibf;
    logic       obf_n;
    logic       intr;
    logic       ovf;
    logic [2:0] lvl;
  } st_t;

  st_t        st_q[$];
  string      st_tag_q[$];
  logic [7:0] rd_q[$];
  string      rd_tag_q[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string tag, int unsigned act, int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endfunction

  // Monitor: compares whenever a status snapshot or a CPU read is presented.
  always @(negedge clk) begin
    st_t        e;
    string      t;
    logic [7:0] d;
    if (snap) begin
      if (st_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL snap: no expectation queued");
      end else begin
        e = st_q.pop_front();
        t = st_tag_q.pop_front();
        chk({t, ".port_out"}, hs.port_out, e.po);
        chk({t, ".port_oe"},  hs.port_oe,  e.oe);
        chk({t, ".ibf"},      hs.ibf,      e.ibf);
        chk({t, ".obf_n"},    hs.obf_n,    e.obf_n);
        chk({t, ".intr"},     hs.intr,     e.intr);
        chk({t, ".ovf"},      hs.ovf,      e.ovf);
        chk({t, ".level"},    hs.level,    e.lvl);
      end
    end
    if (hs.bus_rd) begin
      if (rd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL read: no expectation queued");
      end else begin
        d = rd_q.pop_front();
        t = rd_tag_q.pop_front();
        chk({t, ".bus_dout"}, hs.bus_dout, d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot(string tag, logic [7:0] po, logic oe, logic ibf,
                          logic obf_n, logic intr, logic ovf, logic [2:0] lvl);
    st_t e;
    e.po = po; e.oe = oe; e.ibf = ibf; e.obf_n = obf_n;
    e.intr = intr; e.ovf = ovf; e.lvl = lvl;
    st_q.push_back(e);
    st_tag_q.push_back(tag);
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic rd(string tag, logic [7:0] exp);
    rd_q.push_back(exp);
    rd_tag_q.push_back(tag);
    hs.bus_rd = 1'b1;
    tick();
    hs.bus_rd = 1'b0;
  endtask

  task automatic wr(logic [7:0] d);
    hs.bus_din = d;
    hs.bus_wr  = 1'b1;
    tick();
    hs.bus_wr  = 1'b0;
  endtask

  task automatic cfg(logic m, logic d);
    hs.cfg_mode = m;
    hs.cfg_dir  = d;
    hs.cfg_wr   = 1'b1;
    tick();
    hs.cfg_wr   = 1'b0;
  endtask

  task automatic inte(logic s, logic c);
    hs.inte_set = s;
    hs.inte_clr = c;
    tick();
    hs.inte_set = 1'b0;
    hs.inte_clr = 1'b0;
  endtask

  task automatic strobe(logic [7:0] d);
    hs.port_in = d;
    hs.stb_n   = 1'b0;
    tick();
    hs.stb_n   = 1'b1;
    tick();
  endtask

  task automatic ack();
    hs.ack_n = 1'b0;
    tick();
    hs.ack_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    hs.cfg_wr   = 1'b0; hs.cfg_mode = 1'b0; hs.cfg_dir = 1'b0;
    hs.inte_set = 1'b0; hs.inte_clr = 1'b0;
    hs.bus_rd   = 1'b0; hs.bus_wr   = 1'b0; hs.bus_din = '0;
    hs.port_in  = '0;   hs.stb_n    = 1'b1; hs.ack_n   = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    snapshot("reset", 8'h00, 0, 0, 1, 0, 0, 3'd0);
    rd("reset_rd", 8'h00);

    // Mode 0 output
    cfg(1'b0, 1'b1);
    wr(8'hA5);
    snapshot("m0out_a5", 8'hA5, 1, 0, 1, 0, 0, 3'd0);
    rd("m0out_rd", 8'hA5);
    wr(8'h5A);
    snapshot("m0out_5a", 8'h5A, 1, 0, 1, 0, 0, 3'd0);

    // Mode 1 input, single strobe held low for two cycles
    cfg(1'b1, 1'b0);
    inte(1'b1, 1'b0);
    hs.port_in = 8'h3C;
    hs.stb_n   = 1'b0;
    tick();
    snapshot("m1in_stb_low", 8'h00, 0, 1, 1, 0, 0, 3'd1);
    hs.stb_n   = 1'b1;
    tick();
    snapshot("m1in_stb_high", 8'h00, 0, 1, 1, 1, 0, 3'd1);
    rd("m1in_rd", 8'h3C);
    snapshot("m1in_drained", 8'h00, 0, 0, 1, 0, 0, 3'd0);

    // Mode 1 input overflow
    cfg(1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) strobe(8'(i));
    snapshot("ovf_full", 8'h00, 0, 1, 1, 0, 1, 3'd4);
    rd("ovf_rd1", 8'h01);
    rd("ovf_rd2", 8'h02);
    rd("ovf_rd3", 8'h03);
    rd("ovf_rd4", 8'h04);
    rd("ovf_rd_empty", 8'h00);
    snapshot("ovf_after", 8'h00, 0, 0, 1, 0, 1, 3'd0);

    // Full buffer: read and strobe in the same cycle
    cfg(1'b1, 1'b0);
    strobe(8'h10); strobe(8'h20); strobe(8'h30); strobe(8'h40);
    snapshot("full4", 8'h00, 0, 1, 1, 0, 0, 3'd4);
    hs.port_in = 8'h50;
    hs.stb_n   = 1'b0;
    rd("full_simul_rd", 8'h10);
    hs.stb_n   = 1'b1;
    tick();
    snapshot("full_simul", 8'h00, 0, 1, 1, 0, 0, 3'd4);
    rd("full_rd20", 8'h20);
    rd("full_rd30", 8'h30);
    rd("full_rd40", 8'h40);
    rd("full_rd50", 8'h50);
    snapshot("full_drained", 8'h00, 0, 0, 1, 0, 0, 3'd0);

    // Empty buffer: read and strobe in the same cycle, only the push lands
    hs.port_in = 8'h77;
    hs.stb_n   = 1'b0;
    rd("empty_simul_rd", 8'h00);
    hs.stb_n   = 1'b1;
    tick();
    snapshot("empty_simul", 8'h00, 0, 1, 1, 0, 0, 3'd1);
    rd("empty_simul_rd77", 8'h77);

    // Mode 1 output
    cfg(1'b1, 1'b1);
    inte(1'b1, 1'b0);
    wr(8'h11);
    wr(8'h22);
    snapshot("m1out_two", 8'h11, 1, 0, 0, 1, 0, 3'd2);
    ack();
    snapshot("m1out_ack1", 8'h22, 1, 0, 0, 1, 0, 3'd1);
    ack();
    snapshot("m1out_ack2", 8'h22, 1, 0, 1, 1, 0, 3'd0);
    wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
    snapshot("m1out_full", 8'hA1, 1, 0, 0, 0, 0, 3'd4);
    wr(8'hA5);
    snapshot("m1out_ovf", 8'hA1, 1, 0, 0, 0, 1, 3'd4);
    ack();
    snapshot("m1out_ack3", 8'hA2, 1, 0, 0, 1, 1, 3'd3);
    inte(1'b1, 1'b1);
    snapshot("inte_clr_wins", 8'hA2, 1, 0, 0, 0, 1, 3'd3);
    inte(1'b1, 1'b0);
    snapshot("inte_set", 8'hA2, 1, 0, 0, 1, 1, 3'd3);

    // cfg_wr in the same cycle as bus_wr with three entries queued
    hs.bus_din  = 8'hFF;
    hs.bus_wr   = 1'b1;
    cfg(1'b1, 1'b1);
    hs.bus_wr   = 1'b0;
    snapshot("cfg_flush", 8'h00, 1, 0, 1, 0, 0, 3'd0);
    wr(8'h66);
    snapshot("cfg_inte_off", 8'h66, 1, 0, 0, 0, 0, 3'd1);

    // Mode 0 input, registered pins
    cfg(1'b0, 1'b0);
    hs.port_in = 8'h5A;
    tick();
    rd("m0in_5a", 8'h5A);
    hs.port_in = 8'hC3;
    tick();
    rd("m0in_c3", 8'hC3);
    snapshot("m0in_flags", 8'h00, 0, 0, 1, 0, 0, 3'd0);

    // Reset in the middle of a mode 1 transfer
    cfg(1'b1, 1'b0);
    inte(1'b1, 1'b0);
    strobe(8'h99);
    strobe(8'h98);
    snapshot("pre_reset", 8'h00, 0, 1, 1, 1, 0, 3'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    snapshot("mid_reset", 8'h00, 0, 0, 1, 0, 0, 3'd0);

    for (int i = 0; i < 20 && (st_q.size() != 0 || rd_q.size() != 0); i++) tick();
    if (st_q.size() != 0 || rd_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending expected 0", st_q.size() + rd_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
